fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Sequences the program counter and the instruction-memory request/response handshake for the multicycle RV64 core.
- Owns the PC register and issues one fetch at a time to instruction memory.
- Holds the returned instruction in a one-entry output buffer until decode accepts it.
- Applies branch/jump/trap redirects from execute, including squashing a fetch already in flight.

Parameters:
ADDR_W, 64, PC and memory address width
INST_W, 32, instruction width
RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
redirect_valid_i  in  1  execute requests a PC change this cycle
redirect_pc_i  in  ADDR_W  redirect target, used unmodified
imem_req_valid_o  out  1  fetch request valid
imem_req_addr_o  out  ADDR_W  fetch address (= pc_q)
imem_req_ready_i  in  1  memory accepts request
imem_rsp_valid_i  in  1  instruction response valid (always accepted)
imem_rsp_data_i  in  INST_W  instruction word
imem_rsp_err_i  in  1  access fault for this response
inst_valid_o  out  1  buffered instruction valid to decode
inst_pc_o  out  ADDR_W  PC of buffered instruction
inst_o  out  INST_W  buffered instruction
inst_err_o  out  1  buffered access-fault flag
inst_ready_i  in  1  decode accepts instruction

Behaviour:
- Reset (async assert): pc_q=RESET_PC, state=IDLE, drop_q=0, all valid outputs 0, inst_pc_o/inst_o/inst_err_o=0.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: no request. Advances to REQ on the first clk edge after rst deasserts, so imem_req_valid_o rises in the second post-reset cycle.
- REQ: imem_req_valid_o=1, imem_req_addr_o=pc_q. On imem_req_ready_i, go to WAIT. Address is held stable while unaccepted; redirect is the only exception.
- WAIT: on imem_rsp_valid_i with drop_q=0, latch data, err and pc_q into the buffer, set inst_valid_o next cycle, go to HOLD. With drop_q=1, discard the response, clear drop_q, go to REQ.
- HOLD: inst_valid_o=1 and buffer stable. On inst_ready_i, pc_q<=pc_q+4 (mod 2^ADDR_W, wraps silently), inst_valid_o<=0, go to REQ.
- Zero-wait memory throughput: 1 instruction per 3 cycles (REQ, WAIT, HOLD).
- Redirect has highest priority. In every state, redirect_valid_i sets pc_q<=redirect_pc_i for the next cycle, then:
  - IDLE: remain IDLE for that edge; the normal transition to REQ follows.
  - REQ without handshake: stay REQ; the address changes to the target next cycle.
  - REQ with handshake same cycle: go to WAIT with drop_q=1.
  - WAIT: set drop_q=1. If the response arrives in the same cycle, discard it and go directly to REQ.
  - HOLD: clear inst_valid_o next cycle and go to REQ, even if inst_ready_i is high in the same cycle. Decode must treat redirect as a kill. No +4 is applied.
- Multiple redirects before a response: the last target wins; drop_q stays 1 and only one response is discarded.
- imem_rsp_err_i does not stall the block. The error travels with the instruction; execute raises a trap via redirect.
- A response while not in WAIT is a protocol violation. It is ignored; bench flags it with an assertion.

Decomposition:
- Package ifu_pkg: state enum (IDLE/REQ/WAIT/HOLD), INST_W, ADDR_W, RESET_PC, PC_STEP=4.
- One natural sub-module, fetch_pc_reg: async-reset PC register with load (redirect) and increment enables; the FSM drives both enables.
- Output buffer and FSM stay in fetch_sequencer.

Test Plan:
- Reset release, memory always ready, 1-cycle response, decode always ready -> requests to 0x80000000, 0x80000004, 0x80000008 spaced 3 cycles apart; inst_pc_o matches each.
- imem_req_ready_i low for 4 cycles at 0x80000004 -> valid stays 1 and address held at 0x80000004 throughout; single handshake.
- inst_ready_i low for 5 cycles in HOLD -> inst_o/inst_pc_o stable; no new request until acceptance; next address +4.
- Redirect to 0x80001000 during WAIT for 0x80000008, response 2 cycles later -> response dropped; inst_valid_o stays 0; next request 0x80001000.
- Redirect to 0x80002000 in HOLD with inst_ready_i=1 same cycle -> no +4; inst_valid_o 0 next cycle; next request 0x80002000.
- rst asserted asynchronously mid-WAIT -> outputs zero immediately; after release, fetch restarts at 0x80000000 with drop_q=0.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

   localparam int unsigned ADDR_W = 64;
   localparam int unsigned INST_W = 32;

   localparam logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000;
   localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_e;

   // One-entry output buffer payload handed to decode.
   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
      logic              err;
   } inst_buf_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Redirect, instruction-memory and decode handshakes of the fetch sequencer.
interface fetch_sequencer_if;
   import ifu_pkg::*;

   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;

   logic              imem_req_valid;
   logic [ADDR_W-1:0] imem_req_addr;
   logic              imem_req_ready;

   logic              imem_rsp_valid;
   logic [INST_W-1:0] imem_rsp_data;
   logic              imem_rsp_err;

   logic              inst_valid;
   logic [ADDR_W-1:0] inst_pc;
   logic [INST_W-1:0] inst;
   logic              inst_err;
   logic              inst_ready;

   modport master (
      input  redirect_valid, redirect_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
      input  inst_ready,
      output imem_req_valid, imem_req_addr,
      output inst_valid, inst_pc, inst, inst_err
   );

   modport slave (
      output redirect_valid, redirect_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
      output inst_ready,
      input  imem_req_valid, imem_req_addr,
      input  inst_valid, inst_pc, inst, inst_err
   );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register: redirect load takes priority over sequential increment.
module fetch_pc_reg
   import ifu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              inc,
   input  logic [ADDR_W-1:0] load_pc,
   output logic [ADDR_W-1:0] pc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= load_pc;
      end else if (inc) begin
         pc <= pc + PC_STEP;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch FSM: one outstanding instruction-memory request, one-entry decode buffer,
// redirects squash any in-flight fetch.
module fetch_sequencer
   import ifu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   fetch_sequencer_if.master bus
);

   fetch_state_e      state_q, state_d;
   logic              drop_q, drop_d;
   logic              req_valid_q;
   logic              inst_valid_q;
   logic              pc_load, pc_inc, buf_load;
   logic [ADDR_W-1:0] pc_q;
   inst_buf_t         buf_q;

   fetch_pc_reg u_pc (
      .clk     (clk),
      .rst     (rst),
      .load    (pc_load),
      .inc     (pc_inc),
      .load_pc (bus.redirect_pc),
      .pc      (pc_q)
   );

   // State, drop flag and the valid outputs, all decoded from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         drop_q       <= 1'b0;
         req_valid_q  <= 1'b0;
         inst_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         drop_q       <= drop_d;
         req_valid_q  <= (state_d == REQ);
         inst_valid_q <= (state_d == HOLD);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q <= '0;
      end else if (buf_load) begin
         buf_q <= '{pc: pc_q, inst: bus.imem_rsp_data, err: bus.imem_rsp_err};
      end
   end

   // Redirect always reloads the PC; drop_q marks the one response still owed by memory.
   always_comb begin
      state_d  = state_q;
      drop_d   = drop_q;
      pc_load  = bus.redirect_valid;
      pc_inc   = 1'b0;
      buf_load = 1'b0;

      case (state_q)
         IDLE: begin
            if (!bus.redirect_valid) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (bus.imem_req_ready) begin
               state_d = WAIT;
               drop_d  = bus.redirect_valid;
            end
         end
         WAIT: begin
            if (bus.imem_rsp_valid) begin
               state_d = REQ;
               drop_d  = 1'b0;
               if (!bus.redirect_valid && !drop_q) begin
                  state_d  = HOLD;
                  buf_load = 1'b1;
               end
            end else if (bus.redirect_valid) begin
               drop_d = 1'b1;
            end
         end
         HOLD: begin
            if (bus.redirect_valid) begin
               state_d = REQ;
            end else if (bus.inst_ready) begin
               state_d = REQ;
               pc_inc  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.imem_req_valid = req_valid_q;
   assign bus.imem_req_addr  = pc_q;
   assign bus.inst_valid     = inst_valid_q;
   assign bus.inst_pc        = buf_q.pc;
   assign bus.inst           = buf_q.inst;
   assign bus.inst_err       = buf_q.err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: address-keyed memory model and a
// program-order PC reference, compared by a scoreboard monitor.
module tb_fetch_sequencer;
   import ifu_pkg::*;

   logic clk = 1'b0;
   logic rst;

   fetch_sequencer_if ifc ();

   fetch_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #5 clk = ~clk;

   int n_cmp   = 0;
   int n_bad   = 0;
   int n_deliv = 0;

   // Reference model state
   logic [ADDR_W-1:0] exp_q[$];
   logic [ADDR_W-1:0] exp_pc;
   logic [ADDR_W-1:0] cur_pc;
   bit                cur_valid   = 1'b0;
   bit                outstanding = 1'b0;
   logic [ADDR_W-1:0] out_addr;
   int                mem_wait    = 0;
   int                lat_next    = 0;

   function automatic logic [INST_W-1:0] inst_of(logic [ADDR_W-1:0] a);
      return a[33:2] ^ a[63:32] ^ 32'hA5C3_0F96;
   endfunction

   function automatic logic err_of(logic [ADDR_W-1:0] a);
      return (a[4:2] == 3'd5);
   endfunction

   function automatic logic [ADDR_W-1:0] pick_target();
      if ($urandom_range(0, 7) == 0) return 64'hFFFF_FFFF_FFFF_FFF8;
      return 64'h0000_0000_9000_0000 + 64'($urandom_range(0, 4095)) * 64'd4;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: event not expected by the model", name);
   endtask

   // Program-order model: the next PC changes only on redirect (last wins) or decode accept.
   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
         exp_pc = RESET_PC;
         exp_q.push_back(exp_pc);
         cur_valid   = 1'b0;
         outstanding = 1'b0;
         mem_wait    = 0;
      end else begin
         assert (!ifc.imem_rsp_valid || dut.state_q == WAIT)
            else $error("FAIL rsp_outside_wait: response while not waiting");
         if (ifc.redirect_valid) begin
            exp_pc = ifc.redirect_pc;
            exp_q.delete();
            exp_q.push_back(exp_pc);
            cur_valid = 1'b0;
         end else if (ifc.inst_valid && ifc.inst_ready) begin
            exp_pc = exp_pc + 64'd4;
            exp_q.push_back(exp_pc);
            cur_valid = 1'b0;
            n_deliv++;
         end
         if (outstanding) begin
            if (ifc.imem_rsp_valid) outstanding = 1'b0;
            else if (mem_wait > 0) mem_wait--;
         end else if (ifc.imem_req_valid && ifc.imem_req_ready) begin
            outstanding = 1'b1;
            out_addr    = ifc.imem_req_addr;
            mem_wait    = lat_next;
         end
      end
   end

   // Scoreboard monitor, sampling on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (ifc.imem_req_valid) begin
            if (exp_q.size() == 0) fail("req_unexpected");
            else check("req_addr", ifc.imem_req_addr, exp_q[0]);
         end
         if (ifc.inst_valid) begin
            if (!cur_valid) begin
               if (exp_q.size() == 0) fail("inst_unexpected");
               else begin
                  cur_pc    = exp_q.pop_front();
                  cur_valid = 1'b1;
               end
            end
            if (cur_valid) begin
               check("inst_pc", ifc.inst_pc, cur_pc);
               check("inst", 64'(ifc.inst), 64'(inst_of(cur_pc)));
               check("inst_err", 64'(ifc.inst_err), 64'(err_of(cur_pc)));
            end
         end else if (cur_valid) begin
            fail("inst_lost");
            cur_valid = 1'b0;
         end
      end
   end

   task automatic drive_cycle(input bit rnd);
      @(negedge clk);
      if (outstanding && mem_wait == 0) begin
         ifc.imem_rsp_valid = 1'b1;
         ifc.imem_rsp_data  = inst_of(out_addr);
         ifc.imem_rsp_err   = err_of(out_addr);
      end else begin
         ifc.imem_rsp_valid = 1'b0;
         ifc.imem_rsp_data  = $urandom;
         ifc.imem_rsp_err   = 1'($urandom_range(0, 1));
      end
      if (rnd) begin
         ifc.imem_req_ready = ($urandom_range(0, 9) < 6);
         ifc.inst_ready     = ($urandom_range(0, 9) < 6);
         ifc.redirect_valid = ($urandom_range(0, 11) == 0);
         ifc.redirect_pc    = pick_target();
         lat_next           = int'($urandom_range(0, 3));
      end
   endtask

   // Zero-wait fetch after reset release: requests at +1, +4, +7 cycles to consecutive PCs.
   task automatic restart_check(input string tag);
      int                ks[$];
      logic [ADDR_W-1:0] as[$];
      ifc.imem_req_ready = 1'b1;
      ifc.inst_ready     = 1'b1;
      ifc.redirect_valid = 1'b0;
      lat_next           = 0;
      for (int k = 1; k <= 8; k++) begin
         drive_cycle(1'b0);
         if (ifc.imem_req_valid) begin
            ks.push_back(k);
            as.push_back(ifc.imem_req_addr);
         end
      end
      check({tag, "_req_count"}, 64'(ks.size()), 64'd3);
      for (int i = 0; i < 3 && i < ks.size(); i++) begin
         check({tag, "_req_cycle"}, 64'(ks[i]), 64'(1 + 3 * i));
         check({tag, "_req_pc"}, as[i], RESET_PC + 64'(4 * i));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_valid"}, 64'(ifc.imem_req_valid), 64'd0);
      check({tag, "_req_addr"}, ifc.imem_req_addr, RESET_PC);
      check({tag, "_inst_valid"}, 64'(ifc.inst_valid), 64'd0);
      check({tag, "_inst_pc"}, ifc.inst_pc, 64'd0);
      check({tag, "_inst"}, 64'(ifc.inst), 64'd0);
      check({tag, "_inst_err"}, 64'(ifc.inst_err), 64'd0);
   endtask

   initial begin
      bit seen;
      rst                = 1'b1;
      ifc.redirect_valid = 1'b0;
      ifc.redirect_pc    = '0;
      ifc.imem_req_ready = 1'b0;
      ifc.imem_rsp_valid = 1'b0;
      ifc.imem_rsp_data  = '0;
      ifc.imem_rsp_err   = 1'b0;
      ifc.inst_ready     = 1'b0;

      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst = 1'b0;
      restart_check("boot");

      for (int c = 0; c < 3000; c++) drive_cycle(1'b1);
      check("delivery_progress", 64'(n_deliv > 100), 64'd1);

      // Catch a fetch in WAIT with a slow response, then reset asynchronously.
      ifc.redirect_valid = 1'b0;
      ifc.imem_req_ready = 1'b1;
      ifc.inst_ready     = 1'b1;
      lat_next           = 3;
      seen               = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         drive_cycle(1'b0);
         seen = ifc.imem_req_valid;
      end
      if (!seen) begin
         fail("wait_timeout");
      end else begin
         @(posedge clk);
         #2;
         rst                = 1'b1;
         ifc.imem_rsp_valid = 1'b0;
         #1;
         check_reset_outputs("arst");
         repeat (2) @(negedge clk);
         rst = 1'b0;
         restart_check("rearm");
      end
      repeat (4) drive_cycle(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
